// File: rtl/ballot_input_conditioner.sv
// Front-panel conditioner for votingMachine: sync + debounce of the candidate buttons,
// multi-press rejection and one start/encoder_in ballot per press. Optional counter: BALLOT_CNT_EN.
module ballot_input_conditioner #(
  parameter int N_BUTTONS       = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int START_CYCLES    = 2,
  parameter int GAP_CYCLES      = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  input  logic                 enable,
  output logic [N_BUTTONS-1:0] encoder_in,
  output logic                 start,
  output logic                 busy,
  output logic                 multi_err
`ifdef BALLOT_CNT_EN
  ,
  output logic [9:0]           ballot_count
`endif
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PH_MAX = (START_CYCLES > GAP_CYCLES) ? START_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] ST_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0] GP_LAST = PH_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_RELEASE} state_t;

  logic [N_BUTTONS-1:0] sync1_q, sync2_q;
  logic [N_BUTTONS-1:0] prev_q, prev_d;
  logic [N_BUTTONS-1:0] stable_q, stable_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic [PH_W-1:0]      ph_cnt_q;
  logic [N_BUTTONS-1:0] enc_q;
  logic                 start_q, busy_q, merr_q;
  state_t               state_q;
  logic                 stable_any, stable_multi, stable_one;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // One counter shared by the whole vector: any bit changing restarts the qualification window.
  always_comb begin
    prev_d   = prev_q;
    db_cnt_d = db_cnt_q;
    stable_d = stable_q;
    if (sync2_q != prev_q) begin
      prev_d   = sync2_q;
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = prev_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= '0;
      db_cnt_q <= '0;
      stable_q <= '0;
    end else begin
      prev_q   <= prev_d;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more buttons are down.
  assign stable_any   = |stable_q;
  assign stable_multi = |(stable_q & (stable_q - N_BUTTONS'(1)));
  assign stable_one   = stable_any & ~stable_multi;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      enc_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      merr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && stable_one) begin
            enc_q    <= stable_q;
            start_q  <= 1'b1;
            busy_q   <= 1'b1;
            ph_cnt_q <= '0;
            state_q  <= ISSUE;
          end else if (enable && stable_multi) begin
            merr_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= WAIT_RELEASE;
          end
        end
        ISSUE: begin
          if (ph_cnt_q == ST_LAST) begin
            start_q  <= 1'b0;
            enc_q    <= '0;
            ph_cnt_q <= '0;
            state_q  <= GAP;
          end else begin
            ph_cnt_q <= ph_cnt_q + PH_W'(1);
          end
        end
        GAP: begin
          if (ph_cnt_q == GP_LAST) begin
            ph_cnt_q <= '0;
            state_q  <= WAIT_RELEASE;
          end else begin
            ph_cnt_q <= ph_cnt_q + PH_W'(1);
          end
        end
        WAIT_RELEASE: begin
          if (!stable_any) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          start_q <= 1'b0;
          enc_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign encoder_in = enc_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign multi_err  = merr_q;

`ifdef BALLOT_CNT_EN
  logic [9:0] ballot_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ballot_count_q <= '0;
    end else if (state_q == IDLE && enable && stable_one && ballot_count_q != 10'h3FF) begin
      ballot_count_q <= ballot_count_q + 10'd1;
    end
  end

  assign ballot_count = ballot_count_q;
`endif

endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Bench for ballot_input_conditioner: directed scenarios plus random button traffic,
// all checked against a window/timestamp reference model. Define BALLOT_CNT_EN to cover the counter.
module tb_ballot_input_conditioner;
  localparam int D = 4;
  localparam int S = 2;
  localparam int G = 11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] btn_raw = '0;
  logic        enable = 1'b0;
  logic [15:0] encoder_in;
  logic        start, busy, multi_err;
`ifdef BALLOT_CNT_EN
  logic [9:0]  ballot_count;
`endif

  int total = 0;
  int bad = 0;

  ballot_input_conditioner dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .enable(enable),
    .encoder_in(encoder_in), .start(start), .busy(busy), .multi_err(multi_err)
`ifdef BALLOT_CNT_EN
    , .ballot_count(ballot_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: stable = raw value once D+1 consecutive synchronised samples agree;
  // a ballot is timed from the edge it was issued on.
  logic [15:0] hist [$];
  logic [15:0] m_stable, m_enc;
  logic        m_start, m_busy, m_merr, m_in_ballot, m_wait;
  logic [9:0]  m_count;
  int          m_issue = 0;
  int          cyc = 0;

  always @(posedge clk) begin : model_blk
    logic [15:0] old_stable;
    bit          same;
    int          d;
    old_stable = m_stable;
    if (reset) begin
      m_start = 0; m_enc = '0; m_busy = 0; m_merr = 0;
      m_in_ballot = 0; m_wait = 0; m_stable = '0; m_count = '0;
      hist.delete();
      for (int i = 0; i < D + 3; i++) hist.push_back(16'h0);
    end else begin
      m_merr = 0;
      if (m_in_ballot) begin
        d = cyc - m_issue;
        if (d >= S) begin m_start = 0; m_enc = '0; end
        if (d == S + G) begin m_in_ballot = 0; m_wait = 1; end
      end else if (m_wait) begin
        if (old_stable == 0) begin m_wait = 0; m_busy = 0; end
      end else if (enable && $countones(old_stable) == 1) begin
        m_in_ballot = 1; m_issue = cyc; m_start = 1; m_enc = old_stable; m_busy = 1;
        if (m_count != 10'h3FF) m_count = m_count + 10'd1;
      end else if (enable && $countones(old_stable) >= 2) begin
        m_merr = 1; m_wait = 1; m_busy = 1;
      end
      hist.push_back(btn_raw);
      void'(hist.pop_front());
      same = 1;
      for (int i = 0; i <= D; i++) if (hist[i] != hist[D]) same = 0;
      if (same) m_stable = hist[D];
    end
    cyc++;
  end

  task automatic test_reset;
    reset = 1; enable = 0; btn_raw = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({start, busy, multi_err, encoder_in} !== 19'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {start, busy, multi_err, encoder_in});
    end
`ifdef BALLOT_CNT_EN
    total++;
    if (ballot_count !== 10'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ballot_count); end
`endif
    reset = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL reset_idle j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
    end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_single_press;
    int first = -1, hi = 0, busy_first = -1, busy_last = -1;
    bit enc_ok = 1;
    enable = 1;
    for (int j = 0; j < 60; j++) begin
      btn_raw = (j < 30) ? 16'h0004 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL single_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (start) begin
        if (first < 0) first = j;
        hi++;
        if (encoder_in !== 16'h0004) enc_ok = 0;
      end else if (encoder_in !== 16'h0) enc_ok = 0;
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = j;
        busy_last = j;
      end
    end
    total += 4;
    if (first != 7) begin bad++; $display("FAIL single_latency got=%0d want=7", first); end
    if (hi != 2) begin bad++; $display("FAIL single_width got=%0d want=2", hi); end
    if (!enc_ok) begin bad++; $display("FAIL single_encoder got=0 want=1"); end
    if (busy_first != 7 || busy_last != 36) begin
      bad++; $display("FAIL single_busy got=%0d..%0d want=7..36", busy_first, busy_last);
    end
    $display("test_single_press: ballot at cycle %0d width %0d", first, hi);
  endtask

  task automatic test_bounce;
    int activity = 0;
    enable = 1;
    for (int j = 0; j < 40; j++) begin
      btn_raw = (j < 20 && ((j / 2) % 2 == 0)) ? 16'h0008 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL bounce_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (start !== 1'b0 || busy !== 1'b0 || encoder_in !== 16'h0) activity++;
    end
    total++;
    if (activity != 0) begin bad++; $display("FAIL bounce_quiet got=%0d want=0", activity); end
    $display("test_bounce: no ballot from bouncing input");
  endtask

  task automatic test_multi;
    int errs = 0, early_starts = 0, late_hi = 0;
    bit enc_ok = 1;
    enable = 1;
    for (int j = 0; j < 100; j++) begin
      btn_raw = (j < 20) ? 16'h0081 : (j >= 40 && j < 70) ? 16'h0080 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL multi_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (multi_err === 1'b1) errs++;
      if (start === 1'b1) begin
        if (j < 40) early_starts++;
        else begin late_hi++; if (encoder_in !== 16'h0080) enc_ok = 0; end
      end
    end
    total += 4;
    if (errs != 1) begin bad++; $display("FAIL multi_err_pulses got=%0d want=1", errs); end
    if (early_starts != 0) begin bad++; $display("FAIL multi_no_ballot got=%0d want=0", early_starts); end
    if (late_hi != 2) begin bad++; $display("FAIL multi_followup_width got=%0d want=2", late_hi); end
    if (!enc_ok) begin bad++; $display("FAIL multi_followup_enc got=0 want=1"); end
    $display("test_multi: rejected pair, then ballot for 0080");
  endtask

  task automatic test_enable_gate;
    int first = -1;
    bit enc_ok = 1;
    for (int j = 0; j < 70; j++) begin
      enable  = (j >= 20);
      btn_raw = (j < 40) ? 16'h8000 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL enable_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (start === 1'b1) begin
        if (first < 0) first = j;
        if (encoder_in !== 16'h8000) enc_ok = 0;
      end
    end
    total += 2;
    if (first != 20) begin bad++; $display("FAIL enable_first_start got=%0d want=20", first); end
    if (!enc_ok) begin bad++; $display("FAIL enable_encoder got=0 want=1"); end
    $display("test_enable_gate: ballot issued at cycle %0d", first);
  endtask

  task automatic test_back_to_back;
    int rises = 0, bad_width = 0, run = 0, idle = 1000, min_idle = 1000;
    logic [9:0] count0;
    logic prev_start = 0;
    count0 = m_count;
    enable = 1;
    for (int j = 0; j < 1210; j++) begin
      btn_raw = (j < 1200 && (j % 40) < 20) ? 16'h0001 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL b2b_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (start === 1'b1) begin
        if (!prev_start) begin
          rises++;
          if (rises > 1 && idle < min_idle) min_idle = idle;
          run = 0;
        end
        run++;
      end else begin
        if (prev_start && run != 2) bad_width++;
        if (prev_start) idle = 0;
        idle++;
      end
      prev_start = start;
    end
    total += 3;
    if (rises != 30) begin bad++; $display("FAIL b2b_count got=%0d want=30", rises); end
    if (bad_width != 0) begin bad++; $display("FAIL b2b_width got=%0d want=0", bad_width); end
    if (min_idle < G) begin bad++; $display("FAIL b2b_gap got=%0d want>=%0d", min_idle, G); end
`ifdef BALLOT_CNT_EN
    total++;
    if (ballot_count !== count0 + 10'd30) begin
      bad++; $display("FAIL b2b_ballot_count got=%0d want=%0d", ballot_count, count0 + 10'd30);
    end
`endif
    $display("test_back_to_back: %0d ballots, min idle %0d, start count %0d", rises, min_idle, count0);
  endtask

  task automatic test_reset_mid;
    int first = -1;
    enable = 1;
    for (int j = 0; j < 80; j++) begin
      reset   = (j == 9);
      btn_raw = (j < 40) ? 16'h0004 : 16'h0000;
      @(negedge clk);
      total++;
      if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
        bad++; $display("FAIL rstmid_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
      end
      if (j == 8) begin
        total++;
        if (start !== 1'b1) begin bad++; $display("FAIL rstmid_second_cycle got=%b want=1", start); end
      end
      if (j == 9) begin
        total++;
        if ({start, busy, encoder_in} !== 18'd0) begin
          bad++; $display("FAIL rstmid_cleared got=%h want=0", {start, busy, encoder_in});
        end
      end
      if (j > 9 && start === 1'b1 && first < 0) first = j;
    end
    reset = 0;
    total++;
    if (first != 17) begin bad++; $display("FAIL rstmid_new_ballot got=%0d want=17", first); end
    $display("test_reset_mid: ballot reissued at cycle %0d", first);
  endtask

  task automatic test_random;
    int j = 0, seg_len, kind, errs = 0;
    logic [15:0] pat;
    while (j < 2000) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: pat = 16'h0;
        1: pat = 16'h1 << $urandom_range(0, 15);
        2: pat = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: pat = 16'($urandom);
      endcase
      seg_len = $urandom_range(1, 25);
      enable  = ($urandom_range(0, 4) != 0);
      for (int k = 0; k < seg_len; k++) begin
        btn_raw = pat;
        reset   = ($urandom_range(0, 199) == 0);
        @(negedge clk);
        total++;
        if ({start, busy, multi_err, encoder_in} !== {m_start, m_busy, m_merr, m_enc}) begin
          bad++; errs++;
          $display("FAIL random_model j=%0d got=%h want=%h", j, {start, busy, multi_err, encoder_in}, {m_start, m_busy, m_merr, m_enc});
        end
`ifdef BALLOT_CNT_EN
        total++;
        if (ballot_count !== m_count) begin
          bad++; $display("FAIL random_count j=%0d got=%0d want=%0d", j, ballot_count, m_count);
        end
`endif
        j++;
      end
    end
    reset = 0;
    $display("test_random: %0d cycles, %0d disagreements", j, errs);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_enable_gate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
